// File: rtl/alu_mem_stage.sv
// ---------------------------------------------------------------------------
// alu_mem_stage
//   Execute/memory stage of the 16-bit single-cycle CPU. It decodes the ALU
//   operation, computes the 16-bit ALU result, and uses that result as the
//   byte address of a word-organised data memory.
//
//   Ports
//     Clock         in   1   single clock, all state updates on rising edge
//     Reset_n       in   1   synchronous active-low reset (clears the memory)
//     ALUOp         in   2   ALU class: 00 ADD, 01 SUB, 10 R-type, 11 I-type
//     Funct         in   2   R-type function field
//     Opcode        in   4   instruction opcode
//     A, B          in  16   ALU operands
//     CarryIn       in   1   carry into ADD
//     MemWriteData  in  16   store data
//     MemWrite      in   1   store enable
//     MemRead       in   1   load enable
//     ALUCtrl       out  4   decoded ALU operation
//     Result        out 16   ALU result, also the memory byte address
//     Zero          out  1   Result == 0
//     Overflow      out  1   signed overflow (ADD/SUB only)
//     CarryOut      out  1   carry out of bit 15 (ADD/SUB only)
//     MemReadData   out 16   load data (0 when MemRead is low)
// ---------------------------------------------------------------------------
module alu_mem_stage #(
  parameter int MEM_AW = 7
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [1:0]  ALUOp,
  input  logic [1:0]  Funct,
  input  logic [3:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CarryIn,
  input  logic [15:0] MemWriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] MemReadData
);

  localparam int DEPTH = 2 ** MEM_AW;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  // ---------------- ALU control decode ----------------
  logic [3:0] alu_ctrl;

  always_comb begin
    alu_ctrl = CTRL_ADD;
    unique case (ALUOp)
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      2'b10: begin
        if (Opcode == 4'b0000) begin
          unique case (Funct)
            2'b00:   alu_ctrl = CTRL_ADD;
            2'b01:   alu_ctrl = CTRL_SUB;
            2'b10:   alu_ctrl = CTRL_SLT;
            default: alu_ctrl = CTRL_ADD;
          endcase
        end else if (Opcode == 4'b0001) begin
          unique case (Funct)
            2'b00:   alu_ctrl = CTRL_AND;
            2'b01:   alu_ctrl = CTRL_OR;
            2'b10:   alu_ctrl = CTRL_XOR;
            default: alu_ctrl = CTRL_NOR;
          endcase
        end else begin
          alu_ctrl = CTRL_ADD;
        end
      end
      default: begin
        case (Opcode)
          4'b0100: alu_ctrl = CTRL_ADD;
          4'b0101: alu_ctrl = CTRL_SLT;
          4'b0110: alu_ctrl = CTRL_AND;
          4'b0111: alu_ctrl = CTRL_OR;
          default: alu_ctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  assign ALUCtrl = alu_ctrl;

  // ---------------- ALU ----------------
  logic [16:0] sum_ext;
  logic [16:0] diff_ext;
  logic        sub_ovf;
  logic        slt_bit;
  logic [15:0] result_next;
  logic        ovf_next;
  logic        cout_next;

  assign sum_ext  = {1'b0, A} + {1'b0, B} + {16'b0, CarryIn};
  // Two's-complement subtract; bit 16 set means "no borrow".
  assign diff_ext = {1'b0, A} + {1'b0, ~B} + 17'd1;
  assign sub_ovf  = (A[15] != B[15]) && (diff_ext[15] != A[15]);
  // Sign of the difference is wrong exactly when it overflowed.
  assign slt_bit  = diff_ext[15] ^ sub_ovf;

  always_comb begin
    result_next = 16'h0000;
    ovf_next    = 1'b0;
    cout_next   = 1'b0;
    case (alu_ctrl)
      CTRL_ADD: begin
        result_next = sum_ext[15:0];
        cout_next   = sum_ext[16];
        ovf_next    = (A[15] == B[15]) && (sum_ext[15] != A[15]);
      end
      CTRL_SUB: begin
        result_next = diff_ext[15:0];
        cout_next   = diff_ext[16];
        ovf_next    = sub_ovf;
      end
      CTRL_SLT: result_next = {15'b0, slt_bit};
      CTRL_AND: result_next = A & B;
      CTRL_OR:  result_next = A | B;
      CTRL_XOR: result_next = A ^ B;
      CTRL_NOR: result_next = ~(A | B);
      default:  result_next = 16'h0000;
    endcase
  end

  assign Result   = result_next;
  assign Zero     = (result_next == 16'h0000);
  assign Overflow = ovf_next;
  assign CarryOut = cout_next;

  // ---------------- Data memory ----------------
  // Byte address -> word index; bit 0 and the bits above MEM_AW alias.
  logic [MEM_AW-1:0] word_idx;
  logic [DEPTH-1:0]  word_we;
  logic [15:0]       mem_reg [DEPTH];

  assign word_idx = result_next[MEM_AW:1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign word_we[gi] = MemWrite && (word_idx == MEM_AW'(gi));
    end
  endgenerate

  // Every word is cleared on reset, so this is register storage rather than
  // a block RAM; the read port has to be combinational anyway.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!Reset_n) begin
        mem_reg[i] <= 16'h0000;
      end else if (word_we[i]) begin
        mem_reg[i] <= MemWriteData;
      end
    end
  end

  assign MemReadData = MemRead ? mem_reg[word_idx] : 16'h0000;

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

  localparam int MEM_AW = 7;
  localparam int DEPTH  = 128;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [1:0]  ALUOp;
  logic [1:0]  Funct;
  logic [3:0]  Opcode;
  logic [15:0] A;
  logic [15:0] B;
  logic        CarryIn;
  logic [15:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [3:0]  ALUCtrl;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] MemReadData;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [DEPTH];

  always #5 Clock = ~Clock;

  alu_mem_stage #(.MEM_AW(MEM_AW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ALUOp(ALUOp), .Funct(Funct),
    .Opcode(Opcode), .A(A), .B(B), .CarryIn(CarryIn),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUCtrl(ALUCtrl), .Result(Result), .Zero(Zero), .Overflow(Overflow),
    .CarryOut(CarryOut), .MemReadData(MemReadData)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op,
                                          input logic [3:0] opc,
                                          input logic [1:0] fn);
    logic [3:0] rt_arith [4];
    logic [3:0] rt_logic [4];
    rt_arith = '{4'b0010, 4'b0110, 4'b0111, 4'b0010};
    rt_logic = '{4'b0000, 4'b0001, 4'b0011, 4'b1100};
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b10) begin
      if (opc == 4'd0) return rt_arith[fn];
      if (opc == 4'd1) return rt_logic[fn];
      return 4'b0010;
    end
    if (opc == 4'd4) return 4'b0010;
    if (opc == 4'd5) return 4'b0111;
    if (opc == 4'd6) return 4'b0000;
    if (opc == 4'd7) return 4'b0001;
    return 4'b0010;
  endfunction

  // Arithmetic done in 32-bit integers; flags come from range checks.
  function automatic void ref_alu(input logic [3:0] ctrl, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin,
                                  output logic [15:0] r, output logic ov,
                                  output logic co);
    int sa, sb, ssum;
    int unsigned u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 16'h0000; ov = 1'b0; co = 1'b0;
    case (ctrl)
      4'b0010: begin
        u    = 32'(a) + 32'(b) + 32'(cin);
        r    = u[15:0];
        co   = (u > 32'd65535);
        ssum = sa + sb + int'(cin);
        ov   = (ssum > 32767) || (ssum < -32768);
      end
      4'b0110: begin
        u    = 32'(a) - 32'(b);
        r    = u[15:0];
        co   = (a >= b);
        ssum = sa - sb;
        ov   = (ssum > 32767) || (ssum < -32768);
      end
      4'b0111: r = (sa < sb) ? 16'd1 : 16'd0;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      default: r = 16'h0000;
    endcase
  endfunction

  function automatic int word_of(input logic [15:0] addr);
    return int'(addr / 16'd2) % DEPTH;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] opc, input logic [1:0] fn,
                       input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] wd, input logic mw, input logic mr);
    ALUOp = op; Opcode = opc; Funct = fn; A = a; B = b; CarryIn = cin;
    MemWriteData = wd; MemWrite = mw; MemRead = mr;
    #2;
  endtask

  // Full comparison of all outputs against the model for the current inputs.
  task automatic check_all(input string tag);
    logic [3:0]  c;
    logic [15:0] r;
    logic        ov, co;
    c = ref_ctrl(ALUOp, Opcode, Funct);
    ref_alu(c, A, B, CarryIn, r, ov, co);
    chk({tag, "_ctrl"}, 32'(ALUCtrl), 32'(c));
    chk({tag, "_res"},  32'(Result), 32'(r));
    chk({tag, "_zero"}, 32'(Zero), 32'(r == 16'h0000));
    chk({tag, "_ovf"},  32'(Overflow), 32'(ov));
    chk({tag, "_cout"}, 32'(CarryOut), 32'(co));
    chk({tag, "_rd"},   32'(MemReadData), MemRead ? 32'(mem_m[word_of(r)]) : 32'h0);
  endtask

  // Apply one rising edge, updating the model memory from the current inputs.
  task automatic tick();
    logic [15:0] r;
    logic        ov, co;
    ref_alu(ref_ctrl(ALUOp, Opcode, Funct), A, B, CarryIn, r, ov, co);
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    end else if (MemWrite) begin
      mem_m[word_of(r)] = MemWriteData;
    end
    @(posedge Clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0;
    drive(2'b00, 4'd0, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    Reset_n = 1'b1;

    // Reset state: memory reads zero everywhere.
    drive(2'b00, 4'd0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_rd_0", 32'(MemReadData), 32'h0);
    drive(2'b00, 4'd0, 2'd0, 16'h00FE, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_rd_fe", 32'(MemReadData), 32'h0);

    // Decode sweep over every ALUOp/Opcode/Funct.
    for (int k = 0; k < 64; k++) begin
      drive(k[5:4], k[3:0] & 4'hF, 2'(k % 4), 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      ALUOp = 2'(k / 16); Opcode = 4'(k / 4 % 4 + ((k % 2) * 0)); Funct = 2'(k % 4);
      #1;
      chk("dec_sweep", 32'(ALUCtrl), 32'(ref_ctrl(ALUOp, Opcode, Funct)));
    end
    for (int k = 0; k < 64; k++) begin
      ALUOp = 2'(k / 32 + 2); Opcode = 4'(k % 16); Funct = 2'(k / 16 % 4);
      #1;
      chk("dec_sweep_hi", 32'(ALUCtrl), 32'(ref_ctrl(ALUOp, Opcode, Funct)));
    end
    drive(2'b10, 4'b0001, 2'b11, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("dec_nor", 32'(ALUCtrl), 32'h0000000C);

    // ADD boundaries.
    drive(2'b00, 4'd0, 2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("add_ovf_res", 32'(Result), 32'h8000);
    chk("add_ovf_ovf", 32'(Overflow), 32'h1);
    chk("add_ovf_co",  32'(CarryOut), 32'h0);
    drive(2'b00, 4'd0, 2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("add_wrap_res",  32'(Result), 32'h0);
    chk("add_wrap_zero", 32'(Zero), 32'h1);
    chk("add_wrap_co",   32'(CarryOut), 32'h1);

    // SUB / SLT.
    drive(2'b01, 4'd0, 2'd0, 16'h0005, 16'h0005, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("sub_eq_res",  32'(Result), 32'h0);
    chk("sub_eq_zero", 32'(Zero), 32'h1);
    chk("sub_eq_co",   32'(CarryOut), 32'h1);
    drive(2'b10, 4'd0, 2'b10, 16'h8000, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("slt_neg", 32'(Result), 32'h1);
    drive(2'b10, 4'd0, 2'b10, 16'h0001, 16'h8000, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("slt_pos", 32'(Result), 32'h0);

    // Logic operations.
    drive(2'b10, 4'd1, 2'b00, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("and", 32'(Result), 32'h00F0);
    drive(2'b10, 4'd1, 2'b01, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("or", 32'(Result), 32'hFFF0);
    drive(2'b10, 4'd1, 2'b10, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("xor", 32'(Result), 32'hFF00);
    drive(2'b10, 4'd1, 2'b11, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("nor", 32'(Result), 32'h000F);
    chk("nor_flags", 32'({Overflow, CarryOut}), 32'h0);

    // Memory store/load with aliasing.
    drive(2'b00, 4'd0, 2'd0, 16'h0006, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0);
    tick();
    drive(2'b00, 4'd0, 2'd0, 16'h0006, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("ld_6", 32'(MemReadData), 32'h1234);
    drive(2'b00, 4'd0, 2'd0, 16'h0007, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("ld_7", 32'(MemReadData), 32'h1234);
    drive(2'b00, 4'd0, 2'd0, 16'h0106, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("ld_wrap", 32'(MemReadData), 32'h1234);
    drive(2'b00, 4'd0, 2'd0, 16'h0006, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("ld_off", 32'(MemReadData), 32'h0);

    // Reset with a concurrent store: everything cleared, store discarded.
    Reset_n = 1'b0;
    drive(2'b00, 4'd0, 2'd0, 16'h0006, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b1);
    tick();
    Reset_n = 1'b1;
    drive(2'b00, 4'd0, 2'd0, 16'h0006, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_store_6", 32'(MemReadData), 32'h0);
    drive(2'b00, 4'd0, 2'd0, 16'h0106, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("rst_store_wrap", 32'(MemReadData), 32'h0);

    // Randomized transactions against the model.
    for (int t = 0; t < 250; t++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ra = 16'($urandom_range(0, 600));
        rb = 16'($urandom_range(0, 3));
      end
      Reset_n = ($urandom_range(0, 24) != 0);
      drive(2'($urandom), 4'($urandom), 2'($urandom), ra, rb, 1'($urandom),
            16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      check_all("rnd_pre");
      $display("txn %0d rst_n=%b op=%b opc=%h fn=%b A=%h B=%h cin=%b we=%b re=%b res=%h rd=%h",
               t, Reset_n, ALUOp, Opcode, Funct, A, B, CarryIn, MemWrite, MemRead,
               Result, MemReadData);
      tick();
      check_all("rnd_post");
    end
    Reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
